// File: rtl/drops_pkg.sv
// Shared constants and types for the drops catch game.
package drops_pkg;

    localparam int unsigned COLS        = 8;
    localparam int unsigned DROP_ROWS   = 7;
    localparam int unsigned MAX_MISSES  = 3;
    localparam int unsigned PADDLE_INIT = 3;
    localparam int unsigned COL_W       = $clog2(COLS);
    localparam int unsigned MISS_W      = $clog2(MAX_MISSES + 1);
    localparam int unsigned LFSR_W      = 8;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    // Row 0 is the spawn row, row DROP_ROWS-1 is the row just above the paddle.
    typedef logic [DROP_ROWS-1:0][COLS-1:0] grid_t;

    // Fibonacci LFSR, taps 8,6,5,4; never reaches zero from a nonzero seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

endpackage

// File: rtl/drops_game_btn_cond.sv
// Button conditioning: 2-FF synchronizer followed by a rising-edge detector per button.
module btn_cond (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raw,
    output logic [1:0] synced,
    output logic [1:0] press
);

    logic [1:0] meta;
    logic [1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            synced <= '0;
            prev   <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            prev   <= synced;
        end
    end

    // One-cycle pulse per press; holding a button never repeats.
    assign press = synced & ~prev;

endmodule

// File: rtl/drops_game.sv
// Drops catch game: falling drops, paddle on row 7, score/miss tracking and
// a row-scanned 8x8 LED matrix driver.
module drops_game
    import drops_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4096,
    parameter int unsigned ROW_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned SCAN_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;

    state_t              state, state_nxt;
    grid_t               grid, grid_nxt;
    logic [COL_W-1:0]    paddle, paddle_nxt;
    logic [7:0]          score, score_nxt;
    logic [MISS_W-1:0]   misses, misses_nxt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [LFSR_W-1:0]   lfsr;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [2:0]          row_cnt;
    logic [1:0]          btn_synced;
    logic [1:0]          btn_press;
    logic                step;
    logic [COLS-1:0]     landing;
    logic [COLS-1:0]     spawn;
    logic [7:0][COLS-1:0] frame;
    logic                unused_ok;

    assign unused_ok = ^{ena, ui_in[7:2], uio_in};

    btn_cond u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (ui_in[1:0]),
        .synced (btn_synced),
        .press  (btn_press)
    );

    assign step    = (step_cnt == STEP_W'(STEP_CYCLES - 1));
    assign landing = grid[DROP_ROWS-1];
    assign spawn   = lfsr[0] ? (COLS'(1) << lfsr[3:1]) : '0;

    // Game state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PLAY;
            grid     <= '0;
            paddle   <= COL_W'(PADDLE_INIT);
            score    <= '0;
            misses   <= '0;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grid     <= grid_nxt;
            paddle   <= paddle_nxt;
            score    <= score_nxt;
            misses   <= misses_nxt;
            step_cnt <= step_nxt;
        end
    end

    // Next-state: paddle moves, drop steps and restart from game over.
    always_comb begin
        state_nxt  = state;
        grid_nxt   = grid;
        paddle_nxt = paddle;
        score_nxt  = score;
        misses_nxt = misses;
        step_nxt   = step_cnt;

        unique case (state)
            PLAY: begin
                if (btn_press == 2'b01 && paddle != COL_W'(COLS - 1)) begin
                    paddle_nxt = paddle + COL_W'(1);
                end else if (btn_press == 2'b10 && paddle != '0) begin
                    paddle_nxt = paddle - COL_W'(1);
                end
                step_nxt = step ? '0 : step_cnt + STEP_W'(1);
                if (step) begin
                    // Catch test uses the paddle position before this cycle's move.
                    if (landing != '0) begin
                        if (landing[paddle]) begin
                            if (score != 8'hFF) score_nxt = score + 8'd1;
                        end else begin
                            misses_nxt = misses + MISS_W'(1);
                            if (misses == MISS_W'(MAX_MISSES - 1)) state_nxt = OVER;
                        end
                    end
                    grid_nxt = {grid[DROP_ROWS-2:0], spawn};
                end
            end
            OVER: begin
                if (btn_synced == 2'b11 && btn_press != 2'b00) begin
                    state_nxt  = PLAY;
                    grid_nxt   = '0;
                    paddle_nxt = COL_W'(PADDLE_INIT);
                    score_nxt  = '0;
                    misses_nxt = '0;
                    step_nxt   = '0;
                end
            end
        endcase
    end

    // Free-running LFSR and display scan counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            scan_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            if (scan_cnt == SCAN_W'(ROW_CYCLES - 1)) begin
                scan_cnt <= '0;
                row_cnt  <= row_cnt + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign frame   = {COLS'(1) << paddle, grid};
    assign uo_out  = (state == OVER) ? score : frame[row_cnt];
    assign uio_out = 8'(1) << row_cnt;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_drops_game.sv
// Directed self-checking bench for drops_game: scan, buttons, drops, scoring,
// game over / restart and asynchronous reset.
module tb_drops_game;
    import drops_pkg::*;

    localparam int unsigned STEP = 1024;
    localparam int unsigned ROWC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int compared   = 0;
    int mismatched = 0;
    int edges      = 0;

    logic [7:0] g_m [DROP_ROWS];
    int paddle_m, score_m, misses_m, base, nland;

    drops_game #(.STEP_CYCLES(STEP), .ROW_CYCLES(ROWC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
        logic [7:0] l;
        l = s;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    // Drop spawned by a step on edge e uses the lfsr value from before that edge.
    function automatic logic [7:0] spawn_at(input int e);
        logic [7:0] l;
        logic [7:0] one;
        l   = lfsr_adv(8'hA5, e - 1);
        one = 8'h01;
        return l[0] ? (one << l[3:1]) : 8'h00;
    endfunction

    task automatic press(input logic [1:0] b);
        ui_in = {6'b0, b};
        ticks(20);
        ui_in = 8'h00;
        ticks(20);
    endtask

    task automatic move_to(input int t);
        while (paddle_m < t) begin press(2'b01); paddle_m++; end
        while (paddle_m > t) begin press(2'b10); paddle_m--; end
    endtask

    task automatic read_row(input int r, output logic [7:0] v);
        logic [7:0] sel;
        int n;
        sel = 8'h01 << r;
        n   = 0;
        while (uio_out !== sel && n < 40) begin tick(); n++; end
        chk($sformatf("row_sel%0d", r), uio_out, sel);
        v = uo_out;
    endtask

    // Position the paddle for the coming landing, then run and check step m.
    task automatic step_to(input int m, input bit want_catch);
        int e, col, tgt;
        logic [7:0] landing, v;
        bit late;
        e       = base + m * STEP;
        landing = g_m[DROP_ROWS-1];
        late    = (edges > e);
        if (landing != 8'h00 && !late) begin
            col = 0;
            for (int c = 0; c < 8; c++) if (landing[c]) col = c;
            if (want_catch)          tgt = col;
            else if (paddle_m == col) tgt = (col == 0) ? 1 : col - 1;
            else                     tgt = paddle_m;
            move_to(tgt);
        end
        while (edges < e) tick();
        if (landing != 8'h00) begin
            if (landing[paddle_m]) score_m++;
            else                   misses_m++;
        end
        for (int r = DROP_ROWS - 1; r > 0; r--) g_m[r] = g_m[r-1];
        g_m[0] = spawn_at(e);
        if (!late) begin
            chk($sformatf("lfsr_s%0d", m), dut.lfsr, lfsr_adv(8'hA5, e));
            chk($sformatf("score_s%0d", m), dut.score, 8'(score_m));
            chk($sformatf("misses_s%0d", m), 8'(dut.misses), 8'(misses_m));
            if (misses_m < 3) begin
                for (int r = 0; r < int'(DROP_ROWS); r++) begin
                    read_row(r, v);
                    chk($sformatf("grid_s%0d_r%0d", m, r), v, g_m[r]);
                end
            end else begin
                chk($sformatf("over_s%0d", m), 8'(dut.state), 8'(OVER));
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] sel;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ticks(3);

        // Reset values
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h01);
        chk("rst_oe", uio_oe, 8'hFF);
        chk("rst_lfsr", dut.lfsr, 8'hA5);
        rst_n = 1'b1;
        chk("rel_uio", uio_out, 8'h01);

        // Row scan rotation with empty grid and paddle at column 3
        for (int r = 0; r < 8; r++) begin
            while (edges < r * int'(ROWC) + 2) tick();
            sel = 8'h01 << r;
            chk($sformatf("scan_sel%0d", r), uio_out, sel);
            chk($sformatf("scan_col%0d", r), uo_out, (r == 7) ? 8'h08 : 8'h00);
        end

        for (int r = 0; r < int'(DROP_ROWS); r++) g_m[r] = 8'h00;
        paddle_m = 3; score_m = 0; misses_m = 0; base = 0;

        // Paddle moves, hold without repeat, saturation at 7
        press(2'b01); paddle_m = 4; read_row(7, v); chk("pad_r1", v, 8'h10);
        press(2'b01); paddle_m = 5; read_row(7, v); chk("pad_r2", v, 8'h20);
        press(2'b10); paddle_m = 4; read_row(7, v); chk("pad_l1", v, 8'h10);
        ui_in = 8'h01; ticks(1000); ui_in = 8'h00; ticks(20);
        paddle_m = 5; read_row(7, v); chk("pad_hold", v, 8'h20);
        for (int i = 0; i < 8; i++) begin
            press(2'b01);
            if (paddle_m < 7) paddle_m++;
        end
        read_row(7, v); chk("pad_sat", v, 8'h80);

        // Game 1: catch landings 0 and 2, miss the others until game over
        nland = 0;
        for (int m = 1; m <= 45 && misses_m < 3; m++) begin
            if (g_m[DROP_ROWS-1] != 8'h00) begin
                step_to(m, (nland == 0 || nland == 2));
                nland++;
            end else begin
                step_to(m, 1'b1);
            end
        end
        chk("over_state", 8'(dut.state), 8'(OVER));
        for (int r = 0; r < 8; r++) begin
            read_row(r, v);
            chk($sformatf("over_row%0d", r), v, 8'(score_m));
        end

        // Frozen state in OVER, single presses ignored
        ticks(2 * STEP + 10);
        for (int r = 0; r < int'(DROP_ROWS); r++)
            chk($sformatf("frz_grid%0d", r), dut.grid[r], g_m[r]);
        chk("frz_misses", 8'(dut.misses), 8'd3);
        press(2'b01);
        press(2'b10);
        chk("frz_paddle", 8'(dut.paddle), 8'(paddle_m));
        chk("frz_state", 8'(dut.state), 8'(OVER));
        read_row(7, v); chk("frz_row7", v, 8'(score_m));

        // Restart with both buttons
        ui_in = 8'h03;
        base  = edges + 3;
        ticks(20);
        ui_in = 8'h00;
        ticks(20);
        for (int r = 0; r < int'(DROP_ROWS); r++) g_m[r] = 8'h00;
        paddle_m = 3; score_m = 0; misses_m = 0;
        chk("rs_state", 8'(dut.state), 8'(PLAY));
        chk("rs_score", dut.score, 8'h00);
        chk("rs_misses", 8'(dut.misses), 8'h00);
        read_row(7, v); chk("rs_row7", v, 8'h08);

        // Game 2: catch every drop until the score is nonzero
        for (int m = 1; m <= 40 && score_m < 1; m++) step_to(m, 1'b1);
        chk("g2_score", dut.score, 8'h01);

        // Asynchronous reset mid-game, checked before any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_uo", uo_out, 8'h00);
        chk("arst_uio", uio_out, 8'h01);
        chk("arst_score", dut.score, 8'h00);
        chk("arst_paddle", 8'(dut.paddle), 8'h03);
        chk("arst_lfsr", dut.lfsr, 8'hA5);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
